// File: rtl/pipeline_set_controller.sv
// pipeline_set_controller
//   Sequencer for a settable ring of pipeline registers. Gathers one seed word
//   per stage over a valid/ready port, then on start strobes set for a cycle,
//   lets the ring circulate for a programmed number of cycles and pulses done.
//   Everything except cfg_ready_o is registered; the output flops are decoded
//   from the next state so each one tracks the state it belongs to.
module pipeline_set_controller #(
  parameter int BIT_WIDTH        = 8,
  parameter int NUMBER_OF_STAGES = 4,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  cfg_valid_i,
  input  logic [BIT_WIDTH-1:0]                  cfg_data_i,
  output logic                                  cfg_ready_o,
  input  logic                                  start_i,
  input  logic [COUNT_WIDTH-1:0]                run_cycles_i,
  input  logic                                  abort_i,
  output logic                                  set_o,
  output logic [BIT_WIDTH*NUMBER_OF_STAGES-1:0] set_data_o,
  output logic                                  armed_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  // Index must be at least one bit wide even for a single-stage ring.
  localparam int IDX_W = (NUMBER_OF_STAGES > 1) ? $clog2(NUMBER_OF_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_STAGES - 1);
  localparam int DW = BIT_WIDTH * NUMBER_OF_STAGES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARMED = 3'd2,
    S_SET   = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DW-1:0]          set_data_q, set_data_d;
  logic                   set_q, armed_q, busy_q, done_q;

  logic                   cfg_hs;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;

  // Abort suppresses the handshake so a word offered alongside it is dropped.
  assign cfg_ready_o = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !abort_i;
  assign cfg_hs      = cfg_valid_i && cfg_ready_o;

  // Next-state logic: seed collection, start acceptance and run countdown.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_hs) begin
          wr_en  = 1'b1;
          wr_idx = '0;
          if (NUMBER_OF_STAGES == 1) begin
            idx_d   = '0;
            state_d = S_ARMED;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (cfg_hs) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_ARMED;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      // Run length is captured here so later changes on run_cycles_i are inert.
      S_ARMED: begin
        if (start_i) begin
          cnt_d   = run_cycles_i;
          state_d = S_SET;
        end
      end

      S_SET: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             state_d = S_RUN;
      end

      // Exit on the cycle the counter reads 1, so RUN lasts exactly the
      // programmed length and the counter stops at 0 rather than wrapping.
      S_RUN: begin
        cnt_d = cnt_q - COUNT_WIDTH'(1);
        if (cnt_q <= COUNT_WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a start seen in ARMED.
    if (abort_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // Seed word write into the packed stage image.
  always_comb begin
    set_data_d = set_data_q;
    for (int i = 0; i < NUMBER_OF_STAGES; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i)))
        set_data_d[i*BIT_WIDTH +: BIT_WIDTH] = cfg_data_i;
    end
  end

  // State, index, counter and seed image registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      set_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      set_data_q <= set_data_d;
    end
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      set_q   <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      set_q   <= (state_d == S_SET);
      armed_q <= (state_d == S_ARMED);
      busy_q  <= (state_d == S_SET) || (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign set_o      = set_q;
  assign set_data_o = set_data_q;
  assign armed_o    = armed_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
